// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 4x4 LED matrix scanner.
package led_matrix_pkg;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int ROW_W     = 2;
    localparam int COL_W     = 2;
    localparam int PIX_IDX_W = 4;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    function automatic logic [ROWS-1:0] onehot4(input logic [ROW_W-1:0] row);
        return 4'b0001 << row;
    endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Double-banked 16-pixel brightness store: one write port, one combinational row read.
module led_frame_buf
    import led_matrix_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               wr_en_i,
    input  logic [PIX_IDX_W-1:0]               wr_addr_i,
    input  logic [PWM_BITS-1:0]                wr_data_i,
    input  logic                               wr_bank_i,
    input  logic                               rd_bank_i,
    input  logic [ROW_W-1:0]                   rd_row_i,
    output logic [COLS-1:0][PWM_BITS-1:0]      rd_pix_o
);

    logic [PWM_BITS-1:0] mem_q [2][ROWS*COLS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < ROWS*COLS; p++) begin
                    mem_q[b][p] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Pixel index is row*4+col, so the row number forms the upper address bits.
    always_comb begin
        rd_pix_o = '0;
        for (int c = 0; c < COLS; c++) begin
            rd_pix_o[c] = mem_q[rd_bank_i][{rd_row_i, COL_W'(c)}];
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed PWM scanner for the 4x4 LED matrix with a double-buffered frame store.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int PRESCALE    = 3000,
    parameter int PWM_BITS    = 4,
    parameter int BLANK_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [PIX_IDX_W-1:0]  wr_addr,
    input  logic [PWM_BITS-1:0]   wr_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  frame_start,
    output logic [ROWS-1:0]       aled,
    output logic [COLS-1:0]       kled_oe
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = $clog2(BLANK_TICKS + 1);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLANK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] SLOT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    scan_state_t           state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [PWM_BITS-1:0]   slot_q, slot_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [BLK_W-1:0]      blank_q, blank_d;
    logic                  swap_pend_q, swap_pend_d;
    logic                  front_sel_q, front_sel_d;
    logic                  first_q, first_d;
    logic [ROWS-1:0]       aled_q, aled_d;
    logic [COLS-1:0]       kled_q, kled_d;
    logic                  swap_done_q, swap_done_d;
    logic                  frame_start_q, frame_start_d;
    logic                  tick;
    logic                  boundary;
    logic [COLS-1:0][PWM_BITS-1:0] row_pix;

    led_frame_buf #(
        .PWM_BITS (PWM_BITS)
    ) u_frame_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_bank_i (!front_sel_q),
        .rd_bank_i (front_sel_q),
        .rd_row_i  (row_q),
        .rd_pix_o  (row_pix)
    );

    assign tick     = (presc_q == PRE_LAST);
    assign boundary = en && tick && (state_q == ON) && (slot_q == SLOT_LAST)
                      && (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        slot_d        = slot_q;
        blank_d       = blank_q;
        presc_d       = tick ? '0 : presc_q + PRE_W'(1);
        first_d       = 1'b0;
        swap_pend_d   = swap_pend_q | swap_req;
        front_sel_d   = front_sel_q;
        swap_done_d   = 1'b0;

        if (!en) begin
            state_d = BLANK;
            row_d   = '0;
            slot_d  = '0;
            blank_d = '0;
            presc_d = '0;
            first_d = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                BLANK: begin
                    if (blank_q == BLK_LAST) begin
                        state_d = ON;
                        slot_d  = '0;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + BLK_W'(1);
                    end
                end
                ON: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = BLANK;
                        row_d   = row_q + ROW_W'(1);
                        first_d = 1'b1;
                    end else begin
                        slot_d = slot_q + PWM_BITS'(1);
                    end
                end
            endcase
        end

        // A request arriving on the boundary cycle itself is honoured immediately.
        if (boundary && swap_pend_d) begin
            front_sel_d = !front_sel_q;
            swap_pend_d = 1'b0;
            swap_done_d = 1'b1;
        end

        frame_start_d = en && first_q && (state_q == BLANK) && (row_q == '0);
        aled_d        = (en && state_q == ON) ? onehot4(row_q) : '0;
        kled_d        = '0;
        for (int c = 0; c < COLS; c++) begin
            kled_d[c] = en && (state_q == ON) && (row_pix[c] > slot_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BLANK;
            row_q         <= '0;
            slot_q        <= '0;
            presc_q       <= '0;
            blank_q       <= '0;
            swap_pend_q   <= 1'b0;
            front_sel_q   <= 1'b0;
            first_q       <= 1'b1;
            aled_q        <= '0;
            kled_q        <= '0;
            swap_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            slot_q        <= slot_d;
            presc_q       <= presc_d;
            blank_q       <= blank_d;
            swap_pend_q   <= swap_pend_d;
            front_sel_q   <= front_sel_d;
            first_q       <= first_d;
            aled_q        <= aled_d;
            kled_q        <= kled_d;
            swap_done_q   <= swap_done_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign aled        = aled_q;
    assign kled_oe     = kled_q;
    assign swap_done   = swap_done_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan with PRESCALE=2, BLANK_TICKS=1: row = 32 clk, frame = 128 clk.
module tb_led_matrix_scan;

    typedef logic [15:0][3:0] img_t;

    typedef struct packed {
        logic       chk;
        logic [3:0] aled;
        logic [3:0] kled;
        logic       fs;
        logic       sd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic       swap_done;
    logic       frame_start;
    logic [3:0] aled;
    logic [3:0] kled_oe;

    int   t;
    int   vectors;
    int   miscompares;
    exp_t sb[$];
    int   ph_edge[$];
    img_t ph_img[$];
    img_t fm;
    img_t bm;

    led_matrix_scan #(
        .PRESCALE    (2),
        .PWM_BITS    (4),
        .BLANK_TICKS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .aled        (aled),
        .kled_oe     (kled_oe)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Expected registered outputs after edge tt (edge 1 = first edge with scan running).
    function automatic exp_t model(int tt);
        exp_t e;
        img_t im;
        int   v;
        int   r;
        int   s;
        e     = '0;
        e.chk = 1'b1;
        im    = ph_img[0];
        for (int i = 0; i < ph_edge.size(); i++) begin
            if (ph_edge[i] < tt) im = ph_img[i];
            if (ph_edge[i] == tt) e.sd = 1'b1;
        end
        v    = (tt - 1) % 32;
        r    = ((tt - 1) % 128) / 32;
        e.fs = ((tt - 1) % 128) == 0;
        if (v >= 2) begin
            s      = (v - 2) / 2;
            e.aled = 4'(1 << r);
            for (int c = 0; c < 4; c++) e.kled[c] = int'(im[r*4+c]) > s;
        end
        return e;
    endfunction

    task automatic schedule_swap(int edge_t);
        img_t tmp;
        ph_edge.push_back(edge_t);
        ph_img.push_back(bm);
        tmp = fm;
        fm  = bm;
        bm  = tmp;
    endtask

    task automatic restart_phases();
        ph_edge.delete();
        ph_img.delete();
        ph_edge.push_back(-1000);
        ph_img.push_back(fm);
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({aled, kled_oe, frame_start, swap_done} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_state got %b/%b/%b/%b exp all zero", aled, kled_oe, frame_start, swap_done);
        end
        rst = 1'b0;
        t   = 0;
        fm  = '0;
        bm  = '0;
        restart_phases();
        for (int k = 1; k <= 70; k++) sb.push_back(model(k));
        while (sb.size() > 0) begin
            wr_en   = (t == 10);
            wr_addr = 4'd8;
            wr_data = 4'hF;
            step();
            e = sb.pop_front();
            vectors++;
            if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                miscompares++;
                $display("FAIL first_scan t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                         aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
            end
        end
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (aled !== 4'b0 || kled_oe !== 4'b0) begin
            miscompares++;
            $display("FAIL async_reset got aled=%b kled=%b exp 0000/0000", aled, kled_oe);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({aled, kled_oe, frame_start, swap_done} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_hold got %b/%b/%b/%b exp all zero", aled, kled_oe, frame_start, swap_done);
        end
        rst = 1'b0;
        t   = 0;
        fm  = '0;
        bm  = '0;
        restart_phases();
        for (int k = 1; k <= 40; k++) sb.push_back(model(k));
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                miscompares++;
                $display("FAIL restart t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                         aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
            end
        end
    endtask

    task automatic test_pwm_pixel5();
        exp_t e;
        int   c1 = 0;
        int   other = 0;
        bm[5] = 4'h3;
        schedule_swap(128);
        for (int k = t + 1; k <= 224; k++) sb.push_back(model(k));
        while (sb.size() > 0) begin
            wr_en    = (t == 40);
            wr_addr  = 4'd5;
            wr_data  = 4'h3;
            swap_req = (t == 41);
            step();
            e = sb.pop_front();
            vectors++;
            if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                miscompares++;
                $display("FAIL pwm_pixel5 t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                         aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
            end
            if (t > 128 && t <= 192 && aled == 4'b0010) begin
                if (kled_oe[1]) c1++;
                if ((kled_oe & 4'b1101) != 4'b0) other++;
            end
        end
        vectors++;
        if (c1 != 6 || other != 0) begin
            miscompares++;
            $display("FAIL pixel5_on_time got %0d clk (others %0d) exp 6 clk (others 0)", c1, other);
        end
    endtask

    task automatic test_full_and_off();
        exp_t e;
        int   c0 = 0;
        int   c3 = 0;
        int   multi = 0;
        int   blank_act = 0;
        bm[0]  = 4'hF;
        bm[3]  = 4'h0;
        bm[14] = 4'h1;
        schedule_swap(256);
        for (int k = t + 1; k <= 384; k++) sb.push_back(model(k));
        while (sb.size() > 0) begin
            wr_en = 1'b1;
            case (t)
                224:     begin wr_addr = 4'd0;  wr_data = 4'hF; end
                225:     begin wr_addr = 4'd3;  wr_data = 4'h9; end
                226:     begin wr_addr = 4'd3;  wr_data = 4'h0; end
                227:     begin wr_addr = 4'd14; wr_data = 4'h1; end
                default: wr_en = 1'b0;
            endcase
            swap_req = (t == 228);
            step();
            e = sb.pop_front();
            vectors++;
            if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                miscompares++;
                $display("FAIL full_off t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                         aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
            end
            if (t > 256 && aled == 4'b0001 && kled_oe[0]) c0++;
            if (t > 256 && kled_oe[3]) c3++;
            if ($countones(aled) > 1) multi++;
            if (((t - 1) % 32) < 2 && (aled != 4'b0 || kled_oe != 4'b0)) blank_act++;
        end
        wr_en = 1'b0;
        vectors++;
        if (c0 != 30 || c3 != 0) begin
            miscompares++;
            $display("FAIL full_scale got col0=%0d col3=%0d exp col0=30 col3=0", c0, c3);
        end
        vectors++;
        if (multi != 0 || blank_act != 0) begin
            miscompares++;
            $display("FAIL row_select got multihot=%0d blank_active=%0d exp 0/0", multi, blank_act);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   sd_cnt = 0;
        schedule_swap(512);
        bm[10] = 4'h5;
        schedule_swap(640);
        for (int k = t + 1; k <= 700; k++) sb.push_back(model(k));
        while (sb.size() > 0) begin
            swap_req = (t == 511) || (t == 521);
            wr_en    = (t == 639);
            wr_addr  = 4'd10;
            wr_data  = 4'h5;
            step();
            e = sb.pop_front();
            vectors++;
            if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                miscompares++;
                $display("FAIL back_to_back t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                         aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
            end
            if (swap_done) sd_cnt++;
        end
        swap_req = 1'b0;
        wr_en    = 1'b0;
        vectors++;
        if (sd_cnt != 2) begin
            miscompares++;
            $display("FAIL swap_count got %0d exp 2", sd_cnt);
        end
    endtask

    task automatic test_en_pause();
        exp_t e;
        int   c2 = 0;
        for (int k = t + 1; k <= 760; k++) begin
            if (k <= 710) e = model(k);
            else if (k == 711) e = '0;
            else begin
                e     = '0;
                e.chk = 1'b1;
            end
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            en       = (t < 710);
            swap_req = (t == 730);
            step();
            e = sb.pop_front();
            if (e.chk) begin
                vectors++;
                if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                    miscompares++;
                    $display("FAIL en_low t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                             aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
                end
            end
        end
        swap_req = 1'b0;
        en       = 1'b1;
        t        = 0;
        restart_phases();
        schedule_swap(128);
        for (int k = 1; k <= 200; k++) sb.push_back(model(k));
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            vectors++;
            if ({aled, kled_oe, frame_start, swap_done} !== {e.aled, e.kled, e.fs, e.sd}) begin
                miscompares++;
                $display("FAIL en_resume t=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", t,
                         aled, kled_oe, frame_start, swap_done, e.aled, e.kled, e.fs, e.sd);
            end
            if (t <= 96 && aled == 4'b0100 && kled_oe[2]) c2++;
        end
        vectors++;
        if (c2 != 10) begin
            miscompares++;
            $display("FAIL resume_contents got pixel10 on %0d clk exp 10", c2);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        test_reset();
        test_pwm_pixel5();
        test_full_and_off();
        test_back_to_back();
        test_en_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
